// File: rtl/gecko_mem_arbiter.sv
// gecko_mem_arbiter
//   Shares the single data-memory request port between two requesters:
//   requester 0 (execute-stage loads/stores) and requester 1 (debug/DMA).
//   Grants alternate round-robin and the winning request is captured in an
//   output register, so it reaches memory one cycle after acceptance.
//   Every accepted read pushes the requester index into an in-order tag
//   FIFO. Each read response is steered back to the requester at the FIFO
//   head. Writes produce no response and are not tagged.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     per-requester handshake (bit i = requester i)
//   req_read_enable     per-requester read strobe
//   req_write_enable    per-requester byte write mask
//   req_addr/req_data   per-requester address and write data
//   mem_valid/ready     registered request handshake towards memory
//   mem_read_enable, mem_write_enable, mem_addr, mem_data
//                       forwarded request fields
//   mem_resp_valid/ready/data  read response from memory
//   resp_valid/ready    per-requester response handshake
//   resp_data           response data, shared by both requesters
//   outstanding         number of reads currently in flight
//   resp_error          sticky flag: a response arrived with no tag
module gecko_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [1:0]                             req_valid,
  output logic [1:0]                             req_ready,
  input  logic [1:0]                             req_read_enable,
  input  logic [1:0][DATA_WIDTH/8-1:0]           req_write_enable,
  input  logic [1:0][ADDR_WIDTH-1:0]             req_addr,
  input  logic [1:0][DATA_WIDTH-1:0]             req_data,
  output logic                                   mem_valid,
  input  logic                                   mem_ready,
  output logic                                   mem_read_enable,
  output logic [DATA_WIDTH/8-1:0]                mem_write_enable,
  output logic [ADDR_WIDTH-1:0]                  mem_addr,
  output logic [DATA_WIDTH-1:0]                  mem_data,
  input  logic                                   mem_resp_valid,
  output logic                                   mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]                  mem_resp_data,
  output logic [1:0]                             resp_valid,
  input  logic [1:0]                             resp_ready,
  output logic [DATA_WIDTH-1:0]                  resp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]       outstanding,
  output logic                                   resp_error
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;

  // Output request register
  logic                  r_memValid;
  logic                  r_memRead;
  logic [MASK_W-1:0]     r_memMask;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [DATA_WIDTH-1:0] r_memData;

  // Round-robin pointer: index of the requester favoured on a tie
  logic                  r_priority;

  // Tag FIFO: one bit per entry holds the issuing requester index
  logic [MAX_OUTSTANDING-1:0] r_tags;
  logic [PTR_W-1:0]           r_wrPtr;
  logic [PTR_W-1:0]           r_rdPtr;
  logic [CNT_W-1:0]           r_count;
  logic                       r_respError;

  logic       w_slotFree;
  logic       w_fifoFull;
  logic       w_fifoEmpty;
  logic [1:0] w_eligible;
  logic       w_anyGrant;
  logic       w_grantIdx;
  logic       w_push;
  logic       w_pop;
  logic       w_headTag;

  // Arbitration. Fullness looks only at the registered count, so a response
  // popping in this same cycle does not open room for a new read yet.
  // Grants are suppressed while reset is asserted so nothing is accepted
  // into state that is about to be cleared.
  always_comb begin
    w_slotFree = !r_memValid || mem_ready;
    w_fifoFull = (r_count == CNT_W'(MAX_OUTSTANDING));
    w_eligible = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_eligible[i] = !rst && req_valid[i] && w_slotFree &&
                      (!req_read_enable[i] || !w_fifoFull);
    end
    w_anyGrant = |w_eligible;
    w_grantIdx = 1'b0;
    if (w_eligible == 2'b11) begin
      w_grantIdx = r_priority;
    end else if (w_eligible[1]) begin
      w_grantIdx = 1'b1;
    end
    req_ready = w_anyGrant ? (2'b01 << w_grantIdx) : 2'b00;
    // A read strobe wins over a write mask, so mixed requests are tagged.
    w_push    = w_anyGrant && req_read_enable[w_grantIdx];
  end

  // Response steering. With an empty FIFO a response has no owner; it is
  // accepted and dropped so memory never stalls on it.
  always_comb begin
    w_fifoEmpty    = (r_count == '0);
    w_headTag      = r_tags[r_rdPtr];
    resp_valid     = (mem_resp_valid && !w_fifoEmpty) ? (2'b01 << w_headTag) : 2'b00;
    resp_data      = mem_resp_data;
    mem_resp_ready = w_fifoEmpty ? mem_resp_valid : resp_ready[w_headTag];
    w_pop          = mem_resp_valid && mem_resp_ready && !w_fifoEmpty;
  end

  // Output register: load on grant, otherwise drop valid once memory takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_memValid <= 1'b0;
      r_memRead  <= 1'b0;
      r_memMask  <= '0;
      r_memAddr  <= '0;
      r_memData  <= '0;
      r_priority <= 1'b0;
    end else begin
      if (w_anyGrant) begin
        r_memValid <= 1'b1;
        r_memRead  <= req_read_enable[w_grantIdx];
        r_memMask  <= req_write_enable[w_grantIdx];
        r_memAddr  <= req_addr[w_grantIdx];
        r_memData  <= req_data[w_grantIdx];
        r_priority <= !w_grantIdx;
      end else if (mem_ready) begin
        r_memValid <= 1'b0;
      end
    end
  end

  // Tag FIFO and outstanding count. Pointers wrap naturally because the
  // depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tags      <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_respError <= 1'b0;
    end else begin
      if (w_push) begin
        r_tags[r_wrPtr] <= w_grantIdx;
        r_wrPtr         <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (mem_resp_valid && w_fifoEmpty) begin
        r_respError <= 1'b1;
      end
    end
  end

  assign mem_valid        = r_memValid;
  assign mem_read_enable  = r_memRead;
  assign mem_write_enable = r_memMask;
  assign mem_addr         = r_memAddr;
  assign mem_data         = r_memData;
  assign outstanding      = r_count;
  assign resp_error       = r_respError;

endmodule
